// File: rtl/nano_gpio_arb_pkg.sv
// Shared definitions for the DE0-Nano GPIO Wishbone arbiter.
// The state encoding doubles as the one-hot grant vector.
package nano_gpio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    localparam int MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/nano_tick_edge.sv
// Registered rising-edge detector for slow level signals (tick, NMI button).
// A level held high produces exactly one single-cycle pulse.
module nano_tick_edge (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sig_q <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sig_q <= sig;
            pulse <= sig & ~sig_q;
        end
    end

endmodule

// File: rtl/nano_gpio_arb.sv
// Two-master round-robin Wishbone arbiter in front of the GPIO slave,
// with tick-based eviction of a master that hogs the bus while the other waits.
//
//  state | meaning
//  IDLE  | no grant, slave outputs forced to 0
//  GNT0  | master 0 (Zet CPU) owns the slave
//  GNT1  | master 1 (debug bridge) owns the slave
module nano_gpio_arb
    import nano_gpio_arb_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 1,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          tick,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [1:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [1:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic [DW-1:0] m0_dat_o,
    output logic [DW-1:0] m1_dat_o,
    output logic          m0_ack_o,
    output logic          m1_ack_o,
    output logic          m0_err_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [1:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    arb_state_t state, state_nx;
    logic       last_gnt, last_gnt_nx;
    logic [3:0] hold_cnt, hold_cnt_nx;
    logic [1:0] mask, mask_nx;
    logic [1:0] err_q, err_nx;
    logic [1:0] req;
    logic       tick1;

    nano_tick_edge u_tick_edge (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .sig      (tick),
        .pulse    (tick1)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            hold_cnt <= 4'd0;
            mask     <= 2'b00;
            err_q    <= 2'b00;
        end else begin
            state    <= state_nx;
            last_gnt <= last_gnt_nx;
            hold_cnt <= hold_cnt_nx;
            mask     <= mask_nx;
            err_q    <= err_nx;
        end
    end

    assign req = {m1_cyc_i & ~mask[1], m0_cyc_i & ~mask[0]};

    always_comb begin
        state_nx    = state;
        last_gnt_nx = last_gnt;
        hold_cnt_nx = hold_cnt;
        mask_nx     = mask;
        err_nx      = 2'b00;
        if (!m0_cyc_i) mask_nx[0] = 1'b0;
        if (!m1_cyc_i) mask_nx[1] = 1'b0;

        case (state)
            IDLE: begin
                // Tie goes to whichever master did not own the bus last.
                if (req[0] && (!req[1] || last_gnt)) begin
                    state_nx    = GNT0;
                    last_gnt_nx = 1'b0;
                end else if (req[1]) begin
                    state_nx    = GNT1;
                    last_gnt_nx = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_nx = IDLE;
                end else if (hold_cnt == HOLD_LIM) begin
                    state_nx    = IDLE;
                    err_nx[0]   = 1'b1;
                    mask_nx[0]  = 1'b1;
                    last_gnt_nx = 1'b0;
                end else if (tick1 && m1_cyc_i) begin
                    hold_cnt_nx = hold_cnt + 4'd1;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_nx = IDLE;
                end else if (hold_cnt == HOLD_LIM) begin
                    state_nx    = IDLE;
                    err_nx[1]   = 1'b1;
                    mask_nx[1]  = 1'b1;
                    last_gnt_nx = 1'b1;
                end else if (tick1 && m0_cyc_i) begin
                    hold_cnt_nx = hold_cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state == IDLE || state_nx != state) hold_cnt_nx = 4'd0;
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = 2'b00;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        case (state)
            GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_stb_o = m0_stb_i;
                s_cyc_o = m0_cyc_i;
            end
            GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_stb_o = m1_stb_i;
                s_cyc_o = m1_cyc_i;
            end
            default: ;
        endcase
    end

    assign gnt_o    = state;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & (state == GNT0);
    assign m1_ack_o = s_ack_i & (state == GNT1);
    assign m0_err_o = err_q[0];
    assign m1_err_o = err_q[1];

endmodule
